// File: rtl/execute_muldiv.sv
// Execute stage: single-cycle ALU with forwarding, plus a radix-2 iterative M-extension unit.
// Define EXECUTE_MULDIV_DIV_EN to build the divider (DIV/DIVU/REM/REMU); without it only multiplies are built.

module execute_muldiv #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            validE,
    input  logic            flushE,
    input  logic            mextE,
    input  logic [2:0]      funct3E,
    input  logic            funct7_5E,
    input  logic [2:0]      ALUControlE,
    input  logic            ALUSrcE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] forwardW,
    input  logic [XLEN-1:0] forwardM,
    input  logic [1:0]      Select_A,
    input  logic [1:0]      Select_B,
    input  logic [PC_W-1:0] PCE,
    input  logic [PC_W-1:0] PCPlus4E,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteData,
    output logic            Zero,
    output logic [PC_W-1:0] PCTargetE,
    output logic            stallE,
    output logic            mdoneE
);

    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam int unsigned SH_W  = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic              neg_q, neg_d;
`ifdef EXECUTE_MULDIV_DIV_EN
    logic              rneg_q, rneg_d;
    logic              div0_q, div0_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
`endif

    logic [XLEN-1:0] src_a, src_b_fwd, src_b, alu_res;
    logic [XLEN-1:0] a_mag, b_mag, m_res, mul_res;
    logic [PW-1:0]   prod_c;
    logic            a_signed, b_signed, a_neg, b_neg, start_c;
    logic            unused_pcplus4;

    // Shift-add step: multiplier in the low half, partial product grows in the high half.
    function automatic logic [PW-1:0] mul_step(input logic [PW-1:0] p, input logic [XLEN-1:0] mc);
        logic [XLEN:0] sum;
        sum = {1'b0, p[PW-1:XLEN]} + {1'b0, mc & {XLEN{p[0]}}};
        return {sum, p[XLEN-1:1]};
    endfunction

`ifdef EXECUTE_MULDIV_DIV_EN
    // Restoring step: remainder in the high half, dividend/quotient shifting in the low half.
    function automatic logic [PW-1:0] div_step(input logic [PW-1:0] rq, input logic [XLEN-1:0] d);
        logic [XLEN:0]   rs;
        logic [XLEN-1:0] rem_n;
        rs    = {rq[PW-1:XLEN], rq[XLEN-1]};
        rem_n = XLEN'(rs - {1'b0, d});
        if (rs >= {1'b0, d}) begin
            return {rem_n, rq[XLEN-2:0], 1'b1};
        end
        return {rs[XLEN-1:0], rq[XLEN-2:0], 1'b0};
    endfunction
`endif

    assign unused_pcplus4 = ^PCPlus4E;

    // Forwarding muxes
    always_comb begin
        case (Select_A)
            2'b00:   src_a = RD1E;
            2'b01:   src_a = forwardW;
            2'b10:   src_a = forwardM;
            default: src_a = '0;
        endcase
        case (Select_B)
            2'b00:   src_b_fwd = RD2E;
            2'b01:   src_b_fwd = forwardW;
            2'b10:   src_b_fwd = forwardM;
            default: src_b_fwd = '0;
        endcase
    end

    assign src_b     = ALUSrcE ? ImmExtE : src_b_fwd;
    assign WriteData = src_b_fwd;
    assign PCTargetE = PCE + ImmExtE[PC_W-1:0];

    always_comb begin
        case (ALUControlE)
            3'b000:  alu_res = src_a + src_b;
            3'b001:  alu_res = src_a - src_b;
            3'b010:  alu_res = src_a & src_b;
            3'b011:  alu_res = src_a | src_b;
            3'b100:  alu_res = src_a ^ src_b;
            3'b101:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            3'b110:  alu_res = src_a << src_b[SH_W-1:0];
            default: alu_res = funct7_5E ? XLEN'($signed(src_a) >>> src_b[SH_W-1:0])
                                         : (src_a >> src_b[SH_W-1:0]);
        endcase
    end

    // Signed ops run on magnitudes; the sign is reapplied once the iteration finishes.
    assign a_signed = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] == 2'b01 || funct3E[1:0] == 2'b10);
    assign b_signed = funct3E[2] ? ~funct3E[0] : (funct3E[1:0] == 2'b01);
    assign a_neg    = a_signed & src_a[XLEN-1];
    assign b_neg    = b_signed & src_b[XLEN-1];
    assign a_mag    = a_neg ? (~src_a + XLEN'(1)) : src_a;
    assign b_mag    = b_neg ? (~src_b + XLEN'(1)) : src_b;

    assign start_c  = ~reset & validE & mextE & ~flushE & (state_q == S_IDLE);
    assign stallE   = start_c | (state_q == S_MUL) | (state_q == S_DIV);
    assign mdoneE   = (state_q == S_DONE) & ~flushE;

    // Next state; the first iteration runs in the start cycle on the live operands.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
`ifdef EXECUTE_MULDIV_DIV_EN
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        dvd_d   = dvd_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    op_d  = funct3E;
                    cnt_d = CNT_W'(1);
                    neg_d = a_neg ^ b_neg;
                    if (!funct3E[2]) begin
                        state_d = S_MUL;
                        mcand_d = a_mag;
                        acc_d   = mul_step({{XLEN{1'b0}}, b_mag}, a_mag);
                    end else begin
`ifdef EXECUTE_MULDIV_DIV_EN
                        state_d = S_DIV;
                        mcand_d = b_mag;
                        acc_d   = div_step({{XLEN{1'b0}}, a_mag}, b_mag);
                        rneg_d  = a_neg;
                        div0_d  = (src_b == '0);
                        dvd_d   = src_a;
`else
                        state_d = S_DONE;
`endif
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_step(acc_q, mcand_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_DONE;
            end
            S_DIV: begin
`ifdef EXECUTE_MULDIV_DIV_EN
                acc_d = div_step(acc_q, mcand_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_DONE;
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (flushE && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
`ifdef EXECUTE_MULDIV_DIV_EN
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            dvd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
`ifdef EXECUTE_MULDIV_DIV_EN
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            dvd_q   <= dvd_d;
`endif
        end
    end

    // Sign fix-up and result select for the DONE cycle
    assign prod_c  = neg_q ? (~acc_q + PW'(1)) : acc_q;
    assign mul_res = (op_q[1:0] == 2'b00) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];

`ifdef EXECUTE_MULDIV_DIV_EN
    logic [XLEN-1:0] quo_c, rem_c;
    assign quo_c = div0_q ? '1 : (neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0]);
    assign rem_c = div0_q ? dvd_q : (rneg_q ? (~acc_q[PW-1:XLEN] + XLEN'(1)) : acc_q[PW-1:XLEN]);
    assign m_res = op_q[2] ? (op_q[1] ? rem_c : quo_c) : mul_res;
`else
    assign m_res = op_q[2] ? '0 : mul_res;
`endif

    assign ALUResultE = (state_q == S_DONE) ? m_res : alu_res;
    assign Zero       = (alu_res == '0);

endmodule

// File: tb/tb_execute_muldiv.sv
// Randomized self-checking bench for execute_muldiv (XLEN=32) against a plain-arithmetic reference model.
// Follows EXECUTE_MULDIV_DIV_EN: divide ops expect real results when defined, a 1-cycle zero result otherwise.

module tb_execute_muldiv;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PC_W = 10;
`ifdef EXECUTE_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic            validE, flushE, mextE, funct7_5E, ALUSrcE;
    logic [2:0]      funct3E, ALUControlE;
    logic [XLEN-1:0] RD1E, RD2E, ImmExtE, forwardW, forwardM;
    logic [1:0]      Select_A, Select_B;
    logic [PC_W-1:0] PCE, PCPlus4E;
    logic [XLEN-1:0] ALUResultE, WriteData;
    logic            Zero, stallE, mdoneE;
    logic [PC_W-1:0] PCTargetE;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    execute_muldiv #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .validE(validE), .flushE(flushE), .mextE(mextE),
        .funct3E(funct3E), .funct7_5E(funct7_5E), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .forwardW(forwardW), .forwardM(forwardM),
        .Select_A(Select_A), .Select_B(Select_B), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ALUResultE(ALUResultE), .WriteData(WriteData), .Zero(Zero), .PCTargetE(PCTargetE),
        .stallE(stallE), .mdoneE(mdoneE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference M result from the ISA definition using 64-bit arithmetic
    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: begin
                if (!DIV_EN) return 32'd0;
                if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
                if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
                if (!f3[0]) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    return f3[1] ? 32'(sr) : 32'(sq);
                end
                return f3[1] ? 32'(ua % ub) : 32'(ua / ub);
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] ctl, input logic f7,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = int'(b % 32);
        case (ctl)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << sh;
            default: return f7 ? 32'($signed(a) >>> sh) : (a >> sh);
        endcase
    endfunction

    function automatic logic [31:0] sel_src(input logic [1:0] s, input logic [31:0] r,
                                            input logic [31:0] w, input logic [31:0] m);
        case (s)
            2'd0: return r;
            2'd1: return w;
            2'd2: return m;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble_sources();
        RD1E = $urandom; RD2E = $urandom; forwardW = $urandom; forwardM = $urandom;
    endtask

    // Issue one M op at a negedge, hold it while stalled, scramble all sources after start
    task automatic run_m(input string tag, input logic [2:0] f3, input logic [1:0] s_a,
                         input logic [1:0] s_b, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] a_e, b_e, exp;
        int unsigned stalls, cyc, exp_st;
        bit done;
        scramble_sources();
        case (s_b) 2'd0: RD2E = b; 2'd1: forwardW = b; 2'd2: forwardM = b; default: ; endcase
        case (s_a) 2'd0: RD1E = a; 2'd1: forwardW = a; 2'd2: forwardM = a; default: ; endcase
        a_e = sel_src(s_a, RD1E, forwardW, forwardM);
        b_e = sel_src(s_b, RD2E, forwardW, forwardM);
        Select_A = s_a; Select_B = s_b; funct3E = f3;
        ALUSrcE = 1'b0; flushE = 1'b0; validE = 1'b1; mextE = 1'b1;
        exp    = ref_m(f3, a_e, b_e);
        exp_st = (f3[2] && !DIV_EN) ? 1 : XLEN;
        stalls = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            if (mdoneE) begin
                done = 1'b1;
                check({tag, "_res"}, 64'(ALUResultE), 64'(exp));
            end else begin
                if (stallE) stalls++;
                @(negedge clk);
                cyc++;
                scramble_sources();
            end
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_stall"}, 64'(stalls), 64'(exp_st));
        check({tag, "_lat"}, 64'(cyc), 64'(exp_st));
        validE = 1'b0; mextE = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a_e, b_e, bf_e;
        int unsigned n_done;
        reset = 1'b1; validE = 1'b1; mextE = 1'b1; flushE = 1'b0;
        funct3E = 3'd0; funct7_5E = 1'b0; ALUControlE = 3'd0; ALUSrcE = 1'b0;
        RD1E = 32'd3; RD2E = 32'd4; ImmExtE = '0; forwardW = '0; forwardM = '0;
        Select_A = 2'd0; Select_B = 2'd0; PCE = '0; PCPlus4E = '0;
        #1;
        check("rst_stall", 64'(stallE), 64'd0);
        check("rst_mdone", 64'(mdoneE), 64'd0);
        @(negedge clk); @(negedge clk);
        validE = 1'b0; mextE = 1'b0; reset = 1'b0;
        @(negedge clk);

        // ADD with immediate, then branch target wrap
        validE = 1'b1; ALUControlE = 3'd0; ALUSrcE = 1'b1; Select_A = 2'd0;
        RD1E = 32'd5; ImmExtE = 32'hFFFF_FFFB; PCE = 10'h3F0;
        #1;
        check("add_res", 64'(ALUResultE), 64'd0);
        check("add_zero", 64'(Zero), 64'd1);
        check("add_stall", 64'(stallE), 64'd0);
        ImmExtE = 32'h20;
        #1;
        check("pc_target", 64'(PCTargetE), 64'h010);
        check("add_nzero", 64'(Zero), 64'd0);
        @(negedge clk);
        check("alu_nostall", 64'(stallE), 64'd0);
        validE = 1'b0;

        // Random single-cycle ALU ops
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            validE = 1'b1; mextE = 1'b0;
            ALUControlE = 3'($urandom_range(0, 7)); funct7_5E = 1'($urandom_range(0, 1));
            ALUSrcE = 1'($urandom_range(0, 1));
            Select_A = 2'($urandom_range(0, 3)); Select_B = 2'($urandom_range(0, 3));
            scramble_sources(); ImmExtE = $urandom; PCE = 10'($urandom);
            #1;
            a_e  = sel_src(Select_A, RD1E, forwardW, forwardM);
            bf_e = sel_src(Select_B, RD2E, forwardW, forwardM);
            b_e  = ALUSrcE ? ImmExtE : bf_e;
            check($sformatf("alu%0d_res", i), 64'(ALUResultE), 64'(ref_alu(ALUControlE, funct7_5E, a_e, b_e)));
            check($sformatf("alu%0d_wd", i), 64'(WriteData), 64'(bf_e));
            check($sformatf("alu%0d_pct", i), 64'(PCTargetE), 64'((PCE + ImmExtE[9:0]) % 1024));
            check($sformatf("alu%0d_stall", i), 64'(stallE), 64'd0);
        end
        validE = 1'b0; ALUSrcE = 1'b0;
        @(negedge clk);

        // Directed M ops (divide rows expect zero/1-cycle when the divider is not built)
        run_m("mul_7_m3", 3'd0, 2'd0, 2'd0, 32'd7, 32'hFFFF_FFFD);
        run_m("mulhu_max", 3'd3, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_m("mulh_neg", 3'd1, 2'd1, 2'd0, 32'h8000_0000, 32'h8000_0000);
        run_m("mulhsu", 3'd2, 2'd0, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_m("fwdm_latch", 3'd0, 2'd2, 2'd0, 32'd12345, 32'd678);
        run_m("div_m7_2", 3'd4, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'd2);
        run_m("rem_m7_2", 3'd6, 2'd0, 2'd0, 32'hFFFF_FFF9, 32'd2);
        run_m("divu_x_0", 3'd5, 2'd0, 2'd0, 32'd99, 32'd0);
        run_m("div_ovf", 3'd4, 2'd0, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_m("rem_x_0", 3'd6, 2'd0, 2'd3, 32'hFFFF_FF00, 32'd5);

        // Flush at cycle 10 of a long op
        scramble_sources(); Select_A = 2'd0; Select_B = 2'd0;
        funct3E = DIV_EN ? 3'd4 : 3'd0; validE = 1'b1; mextE = 1'b1;
        repeat (10) @(negedge clk);
        flushE = 1'b1; validE = 1'b0; mextE = 1'b0;
        #1;
        check("flush_busy", 64'(stallE), 64'd1);
        @(negedge clk);
        flushE = 1'b0;
        #1;
        check("flush_stall", 64'(stallE), 64'd0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (mdoneE) n_done++;
        end
        check("flush_nodone", 64'(n_done), 64'd0);

        // Asynchronous reset at cycle 5 of a MUL, then an immediate restart
        @(negedge clk);
        funct3E = 3'd0; validE = 1'b1; mextE = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_stall", 64'(stallE), 64'd0);
        check("rst_mid_mdone", 64'(mdoneE), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_m("post_rst", 3'd0, 2'd0, 2'd0, 32'd1000, 32'd3000);

        // Random M ops with corner-weighted operands
        for (int i = 0; i < 30; i++) begin
            run_m($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be 32 or 64.
REQ-002 Parameter PC_W, default 10, program-counter width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 validE  in  1  an instruction is present in Execute this cycle.
REQ-006 flushE  in  1  kill the Execute instruction, including any in-flight M operation.
REQ-007 mextE  in  1  the instruction is an RV32M/RV64M op; funct3E selects it.
REQ-008 funct3E  in  3; funct7_5E  in  1; ALUControlE  in  3; ALUSrcE  in  1  decode controls.
REQ-009 RD1E, RD2E, ImmExtE, forwardW, forwardM  in  XLEN each  operand and forwarding sources.
REQ-010 Select_A, Select_B  in  2 each  forwarding selects: 00 register, 01 forwardW, 10 forwardM, 11 zero.
REQ-011 PCE, PCPlus4E  in  PC_W each; ImmExtE[PC_W-1:0] is the branch offset.
REQ-012 ALUResultE  out  XLEN  result; WriteData  out  XLEN  forwarded rs2 value.
REQ-013 Zero  out  1  ALU zero flag; PCTargetE  out  PC_W  PCE + offset, modulo 2^PC_W.
REQ-014 stallE  out  1  the hazard unit SHALL freeze F, D and E and bubble M while this is high.
REQ-015 mdoneE  out  1  an M result is on ALUResultE this cycle.

Function
REQ-016 Non-M ops (mextE=0) SHALL be combinational with 0-cycle latency through alu_top, and stallE SHALL stay 0.
REQ-017 FSM states SHALL be IDLE, MUL, DIV and DONE.
REQ-018 IDLE: validE & mextE & ~flushE with funct3[2]=0 SHALL go to MUL; with funct3[2]=1 it SHALL go to DIV.
REQ-019 On leaving IDLE, the forwarded SrcA/SrcB SHALL be latched, because forward sources may change while stalled.
REQ-020 MUL, DIV: the unit SHALL be radix-2 iterative, one bit per cycle, with a counter running XLEN cycles; on count end it SHALL go to DONE.
REQ-021 DONE: mdoneE=1 and ALUResultE=M result for exactly one cycle, then IDLE.
REQ-022 stallE SHALL equal (IDLE & start) | MUL | DIV; it SHALL be 0 in DONE.
REQ-023 Total M latency SHALL be XLEN+1 cycles from start to mdoneE.
REQ-024 MUL ops: 000 MUL low XLEN; 001 MULH s×s; 010 MULHSU s×u; 011 MULHU u×u; high results SHALL be the upper XLEN bits of the 2·XLEN product.
REQ-025 DIV ops: 100 DIV; 101 DIVU; 110 REM; 111 REMU; signed quotient rounds toward zero; remainder sign follows the dividend.
REQ-026 Divide by zero: quotient SHALL be all-ones and remainder SHALL equal the dividend; still XLEN+1 cycles.
REQ-027 Signed overflow (most-negative / -1): quotient SHALL equal the dividend and remainder SHALL be 0.
REQ-028 flushE in MUL, DIV or DONE SHALL force IDLE next cycle with no mdoneE; flush has priority over start.
REQ-029 WriteData SHALL always equal the forwarded SrcB before the immediate mux.

Reset
REQ-030 reset SHALL force IDLE, zero the counter and operand/accumulator registers, and drive stallE=0 and mdoneE=0 immediately, including mid-operation.
REQ-031 After reset deasserts, the first active clock edge SHALL be able to accept a start.

Configuration
REQ-032 Macro EXECUTE_MULDIV_DIV_EN defined: the DIV state and ops 100-111 SHALL be built per REQ-025 to REQ-027.
REQ-033 Macro undefined: no divider hardware SHALL be built; mextE with funct3[2]=1 SHALL complete in one DONE cycle (stallE 1 cycle) with ALUResultE=0.

Verification
REQ-034 XLEN=32, MUL 7×-3 -> stallE high 32 cycles, then mdoneE with ALUResultE=0xFFFFFFEB.
REQ-035 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles.
REQ-036 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU x/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
REQ-037 Start with Select_A=10, then change forwardM during the stall -> result uses the value latched at start.
REQ-038 flushE asserted at cycle 10 of a DIV -> IDLE next cycle, no mdoneE; assert reset at cycle 5 of a MUL -> stallE falls asynchronously.
REQ-039 ADD with ALUSrcE=1, RD1E=5, ImmExtE=-5, PCE=0x3F0, offset=0x20 -> ALUResultE=0, Zero=1, PCTargetE=0x010, stallE=0.
